vx_branch_resolver: RTL and testbench
=====================================

// Module: vx_branch_resolver
// PURPOSE
//  Receiving end of the per-block ALU branch control interface. Captures branch resolutions
//  (valid, wid, taken, dest) from NUM_BLOCKS ALU blocks; the interface has no ready, so every
//  cycle's resolution is accepted. Serialises them into a single PC-update stream toward the
//  warp scheduler and tracks a per-warp "branch pending" stall mask.
// PARAMETERS
//  NUM_BLOCKS  2   number of ALU blocks driving branch control
//  NUM_WARPS   8   warps per core; NW_BITS = UP(CLOG2(NUM_WARPS))
//  PC_BITS     32  branch target width
//  FIFO_DEPTH  8   entries per block queue; must be >= NUM_WARPS
// PORTS
//  clk            in   1                   core clock
//  reset          in   1                   asynchronous, active-high
//  br_valid       in   NUM_BLOCKS          per-block branch resolution strobe
//  br_wid         in   NUM_BLOCKS*NW_BITS  resolving warp id
//  br_taken       in   NUM_BLOCKS          branch taken flag
//  br_dest        in   NUM_BLOCKS*PC_BITS  next PC (target if taken, else PC+4)
//  issue_valid    in   1                   branch instruction issued this cycle
//  issue_wid      in   NW_BITS             warp of issued branch
//  upd_valid      out  1                   PC update valid
//  upd_wid        out  NW_BITS             warp to redirect
//  upd_taken      out  1                   taken flag
//  upd_pc         out  PC_BITS             new PC
//  upd_ready      in   1                   scheduler accepts update
//  stall_mask     out  NUM_WARPS           1 = warp blocked on unresolved branch
//  err_spurious   out  1                   1-cycle pulse: resolution for non-pending warp
//  err_overflow   out  1                   1-cycle pulse: push into full block queue
// BEHAVIOUR
//  - Reset: all queues empty, RR pointer 0, upd_valid/stall_mask/err_* = 0; upd_wid/pc/taken = 0.
//  - Push: br_valid[b] pushes {wid,taken,dest} into queue b in the same cycle. If full, the
//    event is dropped, err_overflow pulses next cycle, and no state changes.
//  - Arbitration: round-robin over non-empty queues; the winner's pointer moves one past the
//    winner. One pop per cycle, only when the output register is empty or firing.
//  - Output register: valid/ready. Fields are stable while upd_valid && !upd_ready. Fire =
//    upd_valid && upd_ready. Latency br_valid@N -> upd_valid@N+1 when uncontended; throughput
//    1/cycle. Empty queue with output free gives upd_valid=0 next cycle.
//  - Bypass: a push into an empty queue that wins arbitration in the same cycle goes straight
//    to the output register (this gives the N+1 latency above).
//  - Stall mask: issue_valid sets bit issue_wid next cycle; fire clears bit upd_wid. Set and
//    clear on the same wid in the same cycle: set wins.
//  - Spurious: an event is spurious if stall_mask[wid]==0 when it reaches the output register.
//    It is still forwarded, and err_spurious pulses on load.
//  - Simultaneous: all NUM_BLOCKS may push in one cycle. They drain in RR order over
//    NUM_BLOCKS cycles. Per-block order is FIFO.
//  - Reset mid-operation: asynchronous clear of all state. In-flight events are discarded.
// CONFIGURATION
//  BRANCH_RESOLVER_STATS_EN: adds ports perf_taken (out, 32) and perf_not_taken (out, 32).
//   They count fires by upd_taken and wrap at 2^32. They reset to 0 and cost zero logic when
//   undefined. Without the macro, these ports and counters do not exist and all other
//   behaviour is identical.
// STRUCTURE
//  - Shared package VX_gpu_pkg: typedef branch_evt_t {wid, taken, dest}; localparam
//    BR_FIFO_DEPTH.
//  - Sub-module vx_branch_evt_fifo: single-clock FIFO of branch_evt_t, instantiated NUM_BLOCKS
//    times, with full/empty/count outputs and async reset.
//  - Top level holds the RR arbiter, output register, stall mask, error pulses and stats.
// TESTING
//  1. Reset; issue wid=3; br_valid[0] wid=3 taken=1 dest=0x80000100 @N -> upd @N+1
//     {3,1,0x80000100}; stall_mask[3]: 0 -> 1 -> 0 after fire.
//  2. Both blocks push @N (wid 1, 2), ready=1 -> updates @N+1 wid1, @N+2 wid2. Repeat with
//     the RR pointer at 1 -> wid2 goes first.
//  3. upd_ready=0 for 5 cycles with 3 queued events -> output held stable. On release, events
//     drain in order, one per cycle, with no loss.
//  4. Resolution for wid=5 with no pending issue -> forwarded, err_spurious=1 for exactly one
//     cycle.
//  5. Fill queue 0 to FIFO_DEPTH with ready=0, push once more -> err_overflow pulse; the
//     dropped event is never output.
//  6. Assert reset mid-drain -> next cycle upd_valid=0 and stall_mask=0. With STATS_EN, 4
//     taken + 2 not-taken fires -> perf_taken=4, perf_not_taken=2.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types: branch resolution event and queue depth.
// Used by the branch resolver and its per-block event queues.
package VX_gpu_pkg;

  localparam int NUM_WARPS     = 8;
  localparam int NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int PC_BITS       = 32;
  localparam int BR_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic               taken;
    logic [PC_BITS-1:0] dest;
  } branch_evt_t;

endpackage

// File: rtl/vx_branch_evt_fifo.sv
// Single-clock show-ahead queue of branch events with async reset.
// Pushes when full and pops when empty are ignored.
module vx_branch_evt_fifo
  import VX_gpu_pkg::*;
#(
  parameter int DEPTH = BR_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  branch_evt_t   din,
  input  logic          pop,
  output branch_evt_t   dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  branch_evt_t     mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] nxt_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= nxt_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/vx_branch_resolver.sv
// Serialises per-block branch resolutions into one PC-update stream.
// Optional BRANCH_RESOLVER_STATS_EN adds taken/not-taken fire counters.
module vx_branch_resolver
  import VX_gpu_pkg::*;
#(
  parameter int NUM_BLOCKS = 2,
  parameter int FIFO_DEPTH = BR_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BLOCKS-1:0]         br_valid,
  input  logic [NUM_BLOCKS*NW_BITS-1:0] br_wid,
  input  logic [NUM_BLOCKS-1:0]         br_taken,
  input  logic [NUM_BLOCKS*PC_BITS-1:0] br_dest,
  input  logic                          issue_valid,
  input  logic [NW_BITS-1:0]            issue_wid,
  output logic                          upd_valid,
  output logic [NW_BITS-1:0]            upd_wid,
  output logic                          upd_taken,
  output logic [PC_BITS-1:0]            upd_pc,
  input  logic                          upd_ready,
`ifdef BRANCH_RESOLVER_STATS_EN
  output logic [31:0]                   perf_taken,
  output logic [31:0]                   perf_not_taken,
`endif
  output logic [NUM_WARPS-1:0]          stall_mask,
  output logic                          err_spurious,
  output logic                          err_overflow
);

  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  branch_evt_t           in_evt [NUM_BLOCKS];
  branch_evt_t           q_head [NUM_BLOCKS];
  branch_evt_t           head   [NUM_BLOCKS];
  logic [CW-1:0]         count  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] full;
  logic [NUM_BLOCKS-1:0] empty;
  logic [NUM_BLOCKS-1:0] req;
  logic [NUM_BLOCKS-1:0] push;
  logic [NUM_BLOCKS-1:0] pop;
  logic [NUM_BLOCKS-1:0] bypass;

  logic [BW-1:0]         rr_ptr;
  logic [BW-1:0]         win_idx;
  logic                  win_found;
  logic                  fire;
  logic                  load;
  branch_evt_t           sel;
  logic [NUM_WARPS-1:0]  mask_nxt;

  assign fire = upd_valid && upd_ready;
  assign load = win_found && (!upd_valid || upd_ready);
  assign sel  = head[win_idx];

  for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
    assign in_evt[b] = '{
      wid:   br_wid[b*NW_BITS +: NW_BITS],
      taken: br_taken[b],
      dest:  br_dest[b*PC_BITS +: PC_BITS]
    };
    // An empty queue competes with its incoming event directly.
    assign req[b]    = (count[b] != '0) || br_valid[b];
    assign head[b]   = empty[b] ? in_evt[b] : q_head[b];
    assign bypass[b] = load && (win_idx == BW'(b)) && empty[b];
    assign pop[b]    = load && (win_idx == BW'(b)) && !empty[b];
    assign push[b]   = br_valid[b] && !full[b] && !bypass[b];

    vx_branch_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[b]),
      .din   (in_evt[b]),
      .pop   (pop[b]),
      .dout  (q_head[b]),
      .full  (full[b]),
      .empty (empty[b]),
      .count (count[b])
    );
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      logic [BW-1:0] idx;
      if (int'(rr_ptr) + i >= NUM_BLOCKS)
        idx = BW'(int'(rr_ptr) + i - NUM_BLOCKS);
      else
        idx = BW'(int'(rr_ptr) + i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    mask_nxt = stall_mask;
    if (fire)        mask_nxt[upd_wid]   = 1'b0;
    if (issue_valid) mask_nxt[issue_wid] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      upd_valid    <= 1'b0;
      upd_wid      <= '0;
      upd_taken    <= 1'b0;
      upd_pc       <= '0;
      stall_mask   <= '0;
      err_spurious <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      stall_mask   <= mask_nxt;
      err_overflow <= |(br_valid & full);
      err_spurious <= load && !stall_mask[sel.wid];
      if (load) begin
        upd_valid <= 1'b1;
        upd_wid   <= sel.wid;
        upd_taken <= sel.taken;
        upd_pc    <= sel.dest;
        rr_ptr    <= (win_idx == BW'(NUM_BLOCKS - 1)) ? '0 : win_idx + BW'(1);
      end else if (fire) begin
        upd_valid <= 1'b0;
      end
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_taken     <= '0;
      perf_not_taken <= '0;
    end else if (fire) begin
      if (upd_taken) perf_taken     <= perf_taken + 32'd1;
      else           perf_not_taken <= perf_not_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_branch_resolver.sv
// Directed bench for vx_branch_resolver (2 blocks, 8 warps).
// Define BRANCH_RESOLVER_STATS_EN to also exercise the fire counters.
module tb_vx_branch_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  br_valid = '0;
  logic [5:0]  br_wid = '0;
  logic [1:0]  br_taken = '0;
  logic [63:0] br_dest = '0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_wid = '0;
  logic        upd_valid;
  logic [2:0]  upd_wid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic        upd_ready = 1'b1;
  logic [7:0]  stall_mask;
  logic        err_spurious;
  logic        err_overflow;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] perf_taken;
  logic [31:0] perf_not_taken;
`endif

  int passed = 0;
  int total  = 0;

  vx_branch_resolver dut (
    .clk            (clk),
    .reset          (reset),
    .br_valid       (br_valid),
    .br_wid         (br_wid),
    .br_taken       (br_taken),
    .br_dest        (br_dest),
    .issue_valid    (issue_valid),
    .issue_wid      (issue_wid),
    .upd_valid      (upd_valid),
    .upd_wid        (upd_wid),
    .upd_taken      (upd_taken),
    .upd_pc         (upd_pc),
    .upd_ready      (upd_ready),
`ifdef BRANCH_RESOLVER_STATS_EN
    .perf_taken     (perf_taken),
    .perf_not_taken (perf_not_taken),
`endif
    .stall_mask     (stall_mask),
    .err_spurious   (err_spurious),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_br();
    br_valid = '0;
    br_taken = '0;
    br_wid   = '0;
    br_dest  = '0;
  endtask

  task automatic set_blk(input int b, input logic [2:0] w,
                         input logic t, input logic [31:0] d);
    br_valid[b]       = 1'b1;
    br_wid[b*3 +: 3]  = w;
    br_taken[b]       = t;
    br_dest[b*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_br();
    issue_valid = 1'b0;
    upd_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    total++;
    if (upd_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", upd_valid);
    else passed++;
    total++;
    if (stall_mask !== 8'h00) $display("FAIL rst_mask got %h want 00", stall_mask);
    else passed++;
    total++;
    if ({err_spurious, err_overflow} !== 2'b00)
      $display("FAIL rst_err got %b want 00", {err_spurious, err_overflow});
    else passed++;
    total++;
    if ({upd_wid, upd_taken, upd_pc} !== 36'h0)
      $display("FAIL rst_fields got %h want 0", {upd_wid, upd_taken, upd_pc});
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    issue_valid = 1'b1;
    issue_wid = 3'd3;
    tick();
    issue_valid = 1'b0;
    total++;
    if (stall_mask !== 8'h08) $display("FAIL t1_mask_set got %h want 08", stall_mask);
    else passed++;
    set_blk(0, 3'd3, 1'b1, 32'h8000_0100);
    tick();
    clr_br();
    total++;
    if ({upd_valid, upd_wid, upd_taken, upd_pc} !== {1'b1, 3'd3, 1'b1, 32'h8000_0100})
      $display("FAIL t1_upd got v=%b w=%0d t=%b pc=%h want 1 3 1 80000100",
               upd_valid, upd_wid, upd_taken, upd_pc);
    else passed++;
    total++;
    if (err_spurious !== 1'b0) $display("FAIL t1_nospur got %b want 0", err_spurious);
    else passed++;
    tick();
    total++;
    if ({upd_valid, stall_mask} !== {1'b0, 8'h00})
      $display("FAIL t1_after_fire got v=%b mask=%h want 0 00", upd_valid, stall_mask);
    else passed++;
  endtask

  task automatic test_rr();
    do_reset();
    set_blk(0, 3'd1, 1'b0, 32'h10);
    set_blk(1, 3'd2, 1'b1, 32'h20);
    tick();
    clr_br();
    total++;
    if ({upd_valid, upd_wid} !== {1'b1, 3'd1})
      $display("FAIL rr_a1 got v=%b w=%0d want 1 1", upd_valid, upd_wid);
    else passed++;
    tick();
    total++;
    if ({upd_valid, upd_wid, upd_pc} !== {1'b1, 3'd2, 32'h20})
      $display("FAIL rr_a2 got v=%b w=%0d pc=%h want 1 2 20", upd_valid, upd_wid, upd_pc);
    else passed++;
    tick();
    total++;
    if (upd_valid !== 1'b0) $display("FAIL rr_a_idle got %b want 0", upd_valid);
    else passed++;
    set_blk(0, 3'd4, 1'b0, 32'h30);
    tick();
    clr_br();
    tick();
    set_blk(0, 3'd1, 1'b0, 32'h10);
    set_blk(1, 3'd2, 1'b1, 32'h20);
    tick();
    clr_br();
    total++;
    if ({upd_valid, upd_wid} !== {1'b1, 3'd2})
      $display("FAIL rr_b1 got v=%b w=%0d want 1 2", upd_valid, upd_wid);
    else passed++;
    tick();
    total++;
    if ({upd_valid, upd_wid} !== {1'b1, 3'd1})
      $display("FAIL rr_b2 got v=%b w=%0d want 1 1", upd_valid, upd_wid);
    else passed++;
    tick();
    total++;
    if (upd_valid !== 1'b0) $display("FAIL rr_b_idle got %b want 0", upd_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    upd_ready = 1'b0;
    set_blk(0, 3'd5, 1'b1, 32'h500);
    tick();
    set_blk(0, 3'd6, 1'b0, 32'h600);
    tick();
    set_blk(0, 3'd7, 1'b1, 32'h700);
    tick();
    clr_br();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({upd_valid, upd_wid, upd_taken, upd_pc} !== {1'b1, 3'd5, 1'b1, 32'h500})
        $display("FAIL bp_hold%0d got v=%b w=%0d pc=%h want 1 5 500",
                 i, upd_valid, upd_wid, upd_pc);
      else passed++;
    end
    upd_ready = 1'b1;
    tick();
    total++;
    if ({upd_valid, upd_wid, upd_taken, upd_pc} !== {1'b1, 3'd6, 1'b0, 32'h600})
      $display("FAIL bp_d1 got v=%b w=%0d pc=%h want 1 6 600", upd_valid, upd_wid, upd_pc);
    else passed++;
    tick();
    total++;
    if ({upd_valid, upd_wid, upd_taken, upd_pc} !== {1'b1, 3'd7, 1'b1, 32'h700})
      $display("FAIL bp_d2 got v=%b w=%0d pc=%h want 1 7 700", upd_valid, upd_wid, upd_pc);
    else passed++;
    tick();
    total++;
    if (upd_valid !== 1'b0) $display("FAIL bp_idle got %b want 0", upd_valid);
    else passed++;
  endtask

  task automatic test_spurious();
    do_reset();
    set_blk(1, 3'd5, 1'b0, 32'h1004);
    tick();
    clr_br();
    total++;
    if ({err_spurious, upd_valid, upd_wid} !== {1'b1, 1'b1, 3'd5})
      $display("FAIL sp_pulse got e=%b v=%b w=%0d want 1 1 5",
               err_spurious, upd_valid, upd_wid);
    else passed++;
    tick();
    total++;
    if (err_spurious !== 1'b0) $display("FAIL sp_one_cycle got %b want 0", err_spurious);
    else passed++;
  endtask

  task automatic test_overflow();
    do_reset();
    upd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_blk(0, 3'(i), 1'b0, 32'h100 + 32'(i) * 32'd4);
      tick();
    end
    total++;
    if (err_overflow !== 1'b0) $display("FAIL ov_early got %b want 0", err_overflow);
    else passed++;
    set_blk(0, 3'd7, 1'b1, 32'hDEAD_0000);
    tick();
    clr_br();
    total++;
    if (err_overflow !== 1'b1) $display("FAIL ov_pulse got %b want 1", err_overflow);
    else passed++;
    tick();
    total++;
    if (err_overflow !== 1'b0) $display("FAIL ov_clear got %b want 0", err_overflow);
    else passed++;
    total++;
    if (upd_pc !== 32'h100) $display("FAIL ov_head got %h want 100", upd_pc);
    else passed++;
    upd_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      tick();
      total++;
      if ({upd_valid, upd_pc} !== {1'b1, 32'h100 + 32'(i) * 32'd4})
        $display("FAIL ov_drain%0d got v=%b pc=%h want 1 %h",
                 i, upd_valid, upd_pc, 32'h100 + 32'(i) * 32'd4);
      else passed++;
    end
    tick();
    total++;
    if (upd_valid !== 1'b0)
      $display("FAIL ov_dropped got v=%b pc=%h want v=0", upd_valid, upd_pc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    upd_ready = 1'b0;
    issue_valid = 1'b1;
    issue_wid = 3'd1;
    tick();
    issue_wid = 3'd2;
    tick();
    issue_valid = 1'b0;
    set_blk(0, 3'd1, 1'b1, 32'h40);
    set_blk(1, 3'd2, 1'b0, 32'h50);
    tick();
    clr_br();
    set_blk(0, 3'd3, 1'b1, 32'h60);
    tick();
    clr_br();
    upd_ready = 1'b1;
    tick();
    total++;
    if ({upd_valid, upd_wid, stall_mask} !== {1'b1, 3'd2, 8'h04})
      $display("FAIL rm_pre got v=%b w=%0d mask=%h want 1 2 04",
               upd_valid, upd_wid, stall_mask);
    else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({upd_valid, stall_mask} !== {1'b0, 8'h00})
      $display("FAIL rm_async got v=%b mask=%h want 0 00", upd_valid, stall_mask);
    else passed++;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({upd_valid, stall_mask} !== {1'b0, 8'h00})
      $display("FAIL rm_discard got v=%b mask=%h want 0 00", upd_valid, stall_mask);
    else passed++;
  endtask

`ifdef BRANCH_RESOLVER_STATS_EN
  task automatic test_stats();
    logic [5:0] pat;
    pat = 6'b101011;
    do_reset();
    total++;
    if ({perf_taken, perf_not_taken} !== 64'h0)
      $display("FAIL st_rst got %0d %0d want 0 0", perf_taken, perf_not_taken);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      set_blk(0, 3'(i), pat[i], 32'h200 + 32'(i));
      tick();
    end
    clr_br();
    tick();
    tick();
    total++;
    if ({perf_taken, perf_not_taken} !== {32'd4, 32'd2})
      $display("FAIL st_counts got %0d %0d want 4 2", perf_taken, perf_not_taken);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_back_to_back();
    test_spurious();
    test_overflow();
    test_reset_mid();
`ifdef BRANCH_RESOLVER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
